// File: rtl/fmmu_byte_engine_if.sv
// Bundle of header, payload-stream and process-RAM bus signals for fmmu_byte_engine.
// The engine connects through the slave modport; the surrounding frame/bus logic uses master.
interface fmmu_byte_engine_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LOG_W  = 32
) ();

  // datagram header
  logic              sof_valid;
  logic              sof_ready;
  logic [LOG_W-1:0]  sub_address;
  logic [7:0]        sub_len;
  logic [1:0]        sub_cmd;

  // FMMU window configuration, sampled with the header
  logic [LOG_W-1:0]  fmmu_logic_address_start;
  logic [7:0]        fmmu_logic_length;
  logic [ADDR_W-1:0] fmmu_physical_address_start;

  // payload byte stream in
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;

  // payload byte stream out
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;

  // process-RAM bus port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  // datagram completion
  logic              done;
  logic [1:0]        wkc_add;

  modport slave (
    input  sof_valid, sub_address, sub_len, sub_cmd,
    input  fmmu_logic_address_start, fmmu_logic_length, fmmu_physical_address_start,
    input  in_valid, in_data, out_ready, mem_rdata, mem_ack,
    output sof_ready, in_ready, out_valid, out_data,
    output mem_req, mem_we, mem_addr, mem_wdata, done, wkc_add
  );

  modport master (
    output sof_valid, sub_address, sub_len, sub_cmd,
    output fmmu_logic_address_start, fmmu_logic_length, fmmu_physical_address_start,
    output in_valid, in_data, out_ready, mem_rdata, mem_ack,
    input  sof_ready, in_ready, out_valid, out_data,
    input  mem_req, mem_we, mem_addr, mem_wdata, done, wkc_add
  );

endinterface

// File: rtl/fmmu_byte_engine.sv
// FMMU byte engine: maps each payload byte's logical address through one FMMU window
// and performs the matching process-RAM access (LRD overlays read data, LWR writes).
// Optional macro FMMU_LRW_EN: LRW hit bytes do a read followed by a write at the same
// physical address; without it LRW bytes pass through untouched.
module fmmu_byte_engine #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LOG_W  = 32
) (
  input logic               clk,
  input logic               RST,
  fmmu_byte_engine_if.slave bus
);

  localparam int unsigned LAD_W = LOG_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BYTE = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] CMD_LRD = 2'b01;
  localparam logic [1:0] CMD_LWR = 2'b10;
`ifdef FMMU_LRW_EN
  localparam logic [1:0] CMD_LRW = 2'b11;

  localparam logic [1:0] PH_RD  = 2'd0;
  localparam logic [1:0] PH_GAP = 2'd1;
  localparam logic [1:0] PH_WR  = 2'd2;
`endif

  // control state
  logic [2:0]        state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic              hit_q, hit_d;

  // header and window snapshot
  logic [LOG_W-1:0]  sub_addr_q, sub_addr_d;
  logic [7:0]        sub_len_q, sub_len_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [LOG_W-1:0]  win_start_q, win_start_d;
  logic [7:0]        win_len_q, win_len_d;
  logic [ADDR_W-1:0] phys_start_q, phys_start_d;

`ifdef FMMU_LRW_EN
  logic [1:0]        ph_q, ph_d;
`endif

  // registered outputs
  logic              sof_ready_q, sof_ready_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic [1:0]        wkc_add_q, wkc_add_d;

  // per-byte mapping
  logic [LAD_W-1:0]  lad_c;
  logic [LAD_W-1:0]  win_lo_c;
  logic [LAD_W-1:0]  win_hi_c;
  logic              map_hit_c;
  logic [ADDR_W-1:0] phys_c;
  logic              bus_op_c;
  logic              mem_fire_c;
  logic [1:0]        wkc_c;

  // Logical address of the current byte and window test, all one bit wider so a
  // carry out of the logical space can never alias into the window.
  assign lad_c     = {1'b0, sub_addr_q} + LAD_W'(idx_q);
  assign win_lo_c  = {1'b0, win_start_q};
  assign win_hi_c  = win_lo_c + LAD_W'(win_len_q);
  assign map_hit_c = (win_len_q != 8'd0) && !lad_c[LOG_W] &&
                     (lad_c >= win_lo_c) && (lad_c < win_hi_c);
  assign phys_c    = phys_start_q + (lad_c[ADDR_W-1:0] - win_start_q[ADDR_W-1:0]);

  // Commands that touch the bus on a window hit.
`ifdef FMMU_LRW_EN
  assign bus_op_c  = (cmd_q == CMD_LRD) || (cmd_q == CMD_LWR) || (cmd_q == CMD_LRW);
`else
  assign bus_op_c  = (cmd_q == CMD_LRD) || (cmd_q == CMD_LWR);
`endif

  // An ack only counts while a request is actually on the bus.
  assign mem_fire_c = mem_req_q && bus.mem_ack;

  // Working-counter increment for the datagram, given the hit flag.
  always_comb begin
    wkc_c = 2'd0;
    if (hit_q) begin
      case (cmd_q)
        CMD_LRD: wkc_c = 2'd1;
        CMD_LWR: wkc_c = 2'd2;
`ifdef FMMU_LRW_EN
        CMD_LRW: wkc_c = 2'd3;
`endif
        default: wkc_c = 2'd0;
      endcase
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    sub_addr_d   = sub_addr_q;
    sub_len_d    = sub_len_q;
    cmd_d        = cmd_q;
    win_start_d  = win_start_q;
    win_len_d    = win_len_q;
    phys_start_d = phys_start_q;
`ifdef FMMU_LRW_EN
    ph_d         = ph_q;
`endif
    out_data_d   = out_data_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.sof_valid && sof_ready_q) begin
          sub_addr_d   = bus.sub_address;
          sub_len_d    = bus.sub_len;
          cmd_d        = bus.sub_cmd;
          win_start_d  = bus.fmmu_logic_address_start;
          win_len_d    = bus.fmmu_logic_length;
          phys_start_d = bus.fmmu_physical_address_start;
          state_d      = (bus.sub_len == 8'd0) ? S_DONE : S_BYTE;
        end
      end

      S_BYTE: begin
        if (bus.in_valid && in_ready_q) begin
          out_data_d = bus.in_data;
          if (map_hit_c && bus_op_c) begin
            mem_addr_d  = phys_c;
            mem_wdata_d = bus.in_data;
            mem_we_d    = (cmd_q == CMD_LWR);
`ifdef FMMU_LRW_EN
            ph_d        = PH_RD;
`endif
            state_d     = S_MEM;
          end else begin
            state_d = S_OUT;
          end
        end
      end

      S_MEM: begin
`ifdef FMMU_LRW_EN
        if (cmd_q == CMD_LRW) begin
          // read, one idle bus cycle, then write of the incoming byte
          case (ph_q)
            PH_RD: begin
              if (mem_fire_c) begin
                out_data_d = bus.mem_rdata;
                mem_we_d   = 1'b1;
                ph_d       = PH_GAP;
              end
            end
            PH_GAP: ph_d = PH_WR;
            default: begin
              if (mem_fire_c) begin
                hit_d   = 1'b1;
                state_d = S_OUT;
              end
            end
          endcase
        end else
`endif
        if (mem_fire_c) begin
          if (cmd_q == CMD_LRD) begin
            out_data_d = bus.mem_rdata;
          end
          hit_d   = 1'b1;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (bus.out_ready && out_valid_q) begin
          if (idx_q == (sub_len_q - 8'd1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_BYTE;
          end
        end
      end

      S_DONE: begin
        hit_d   = 1'b0;
        idx_d   = 8'd0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    sof_ready_d = (state_d == S_IDLE);
    in_ready_d  = (state_d == S_BYTE);
    out_valid_d = (state_d == S_OUT);
    done_d      = (state_d == S_DONE);
    wkc_add_d   = done_d ? wkc_c : 2'd0;
    mem_req_d   = (state_d == S_MEM);
`ifdef FMMU_LRW_EN
    if (ph_d == PH_GAP) begin
      mem_req_d = 1'b0;
    end
`endif
  end

  // State, snapshot and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= S_IDLE;
      idx_q        <= 8'd0;
      hit_q        <= 1'b0;
      sub_addr_q   <= '0;
      sub_len_q    <= 8'd0;
      cmd_q        <= 2'd0;
      win_start_q  <= '0;
      win_len_q    <= 8'd0;
      phys_start_q <= '0;
`ifdef FMMU_LRW_EN
      ph_q         <= 2'd0;
`endif
      sof_ready_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'd0;
      done_q       <= 1'b0;
      wkc_add_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_q        <= hit_d;
      sub_addr_q   <= sub_addr_d;
      sub_len_q    <= sub_len_d;
      cmd_q        <= cmd_d;
      win_start_q  <= win_start_d;
      win_len_q    <= win_len_d;
      phys_start_q <= phys_start_d;
`ifdef FMMU_LRW_EN
      ph_q         <= ph_d;
`endif
      sof_ready_q  <= sof_ready_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      wkc_add_q    <= wkc_add_d;
    end
  end

  assign bus.sof_ready = sof_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.done      = done_q;
  assign bus.wkc_add   = wkc_add_q;

endmodule

// File: doc/fmmu_byte_engine.md
Name: fmmu_byte_engine

Overview:
- Executes FMMU mapping on the datagram payload byte stream: converts each byte's logical address to a physical ESC address and performs the memory access.
- LRD: reads physical memory and overlays the byte into the outgoing frame.
- LWR: writes the incoming frame byte into physical memory.
- Sits between the frame byte path and the ESC process-RAM bus port, and produces the working-counter increment per datagram.

Parameters:
- ADDR_W, 16, physical bus address width
- LOG_W, 32, logical address width

Ports:
- clk  in  1  system clock
- RST  in  1  synchronous, active-high reset
- sof_valid  in  1  datagram header valid
- sof_ready  out  1  header accepted; high only in IDLE
- sub_address  in  32  logical start address of datagram
- sub_len  in  8  payload bytes; 0 = no payload
- sub_cmd  in  2  01 LRD, 10 LWR, 11 LRW, 00 no-op
- fmmu_logic_address_start  in  32  window logical start
- fmmu_logic_length  in  8  window length; 0 = disabled
- fmmu_physical_address_start  in  16  window physical start
- in_valid / in_ready / in_data  in / out / 8  payload in
- out_valid / out_ready / out_data  out / in / 8  payload out
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  16  physical byte address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid in ack cycle
- mem_ack  in  1  transfer complete
- done  out  1  one-cycle pulse at datagram end
- wkc_add  out  2  WKC increment, valid with done

Behaviour:
- States: IDLE, BYTE, MEM, OUT, DONE.
- Reset: all outputs 0, state IDLE, byte index 0, hit flag 0. Reset in any state aborts the datagram: no done pulse, mem_req drops in the next cycle.
- IDLE: sof_ready=1. On sof_valid, latch sub_address, sub_len, sub_cmd and all three fmmu_* inputs; the fmmu_* inputs are ignored thereafter until the next header. Go to BYTE if sub_len≠0, else DONE.
- BYTE: in_ready=1; all other handshakes low. On in_valid, latch in_data and compute the per-byte mapping:
  - lad = sub_address + idx, computed 33-bit; a carry means no hit.
  - hit = fmmu_logic_length≠0 and start ≤ lad < start + length, compared 33-bit; no wrap.
  - phys = fmmu_physical_address_start + (lad − start)[15:0], modulo 2^16.
  - If hit and cmd∈{LRD, LWR}: go to MEM. Otherwise: go to OUT with data unchanged.
- MEM: mem_req=1, with mem_addr, mem_we and mem_wdata held stable until mem_ack is sampled high.
  - mem_we=1 for LWR (wdata = latched byte); mem_we=0 for LRD.
  - On ack: for LRD, the output byte becomes mem_rdata. Set the hit flag, go to OUT.
  - mem_ack while mem_req=0 is ignored. Ack in the first req cycle is legal.
- OUT: out_valid=1 with out_data stable until out_ready. On handshake:
  - idx==sub_len−1: go to DONE.
  - otherwise: idx++ and go to BYTE.
- DONE: done=1 for one cycle. wkc_add = 1 (LRD) or 2 (LWR) if the hit flag is set, else 0. Clear the hit flag and idx, go to IDLE.
- Minimum 2 cycles per unmapped byte; mapped byte = 2 + bus latency.
- cmd 00: bytes pass through unchanged, wkc_add=0.

Optional Feature:
- Macro: FMMU_LRW_EN.
- Defined: LRW hit bytes do a read then a write at the same phys address; both complete in MEM as two sequential req/ack transactions, with mem_req dropping for one cycle between them. The output byte is the old read data. wkc_add=3 when any byte hit.
- Undefined: LRW is treated as no-op; bytes pass through, no bus activity, wkc_add=0.

Test Plan:
- Window 0x00001000 / len 8 / phys 0x0400, LWR sub 0x00001002 len 4, bytes AA BB CC DD -> four writes to 0x0402..0x0405 with AA..DD; output equals input; done with wkc_add=2.
- Same window, LRD sub 0x00000FFE len 4; memory 0x0400=11, 0x0401=22 -> output bytes 00,00 pass-through, then 11,22; reads only at 0x0400/0x0401; wkc_add=1.
- LRD sub 0x00002000 len 3 (no overlap) -> no mem_req, bytes unchanged, wkc_add=0. Window len 0 -> same response.
- sub_address 0xFFFFFFFE len 4, window start 0xFFFFFFFF len 8 -> only byte 1 hits (phys start+0); bytes 2, 3 wrap and do not hit.
- Backpressure and edge cases:
  - out_ready low 5 cycles and mem_ack delayed 3 cycles -> data and address stable, no byte lost or duplicated.
  - RST asserted in MEM -> mem_req 0 the next cycle, no done.
  - sub_len 0 -> done on the cycle after header accept.
- FMMU_LRW_EN: LRW sub 0x00001000 len 1, mem 0x0400=5A, input 77 -> read 0x0400 then write 77, output 5A, wkc_add=3. Undefined -> no bus, output 77, wkc_add=0.
